sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Upstream feeder for sha256_module. Accepts a message as a stream of 32-bit words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It emits one or more 512-bit blocks and pulses the hasher's start for each block. It holds each block stable until the hasher's done, then builds the next one.

Parameters:
LEN_W, 64, width of the internal message bit-length counter (2..64); the length field is zero-extended to 64 bits.
MAX_WORDS, 1024, maximum accepted message words; words beyond this are accepted and dropped, and the overflow flag is set.

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  upstream word valid
in_ready  out  1  padder accepts a word this cycle
in_data  in  32  message word; first message byte in bits [31:24]
in_last  in  1  final word of the message
in_bytes  in  3  valid bytes in the last word, 1..4 (0 and 5..7 treated as 4); ignored when in_last=0
blk_data  out  512  padded block; word i at bits [32i+31:32i] (word 0 in [31:0])
blk_start  out  1  one-cycle pulse; blk_data valid and held until hash_done
blk_last  out  1  current block is the final block of the message
hash_done  in  1  hasher done pulse
msg_done  out  1  one-cycle pulse after the final block's hash_done
overflow  out  1  sticky; message exceeded MAX_WORDS; cleared on the next message's first accepted word

Behaviour:
- Reset (async assert, sync release): state=IDLE, blk_data=0, blk_start=0, blk_last=0, msg_done=0, overflow=0, in_ready=0, word index widx=0, bit length=0.
- Handshake: a word transfers when in_valid && in_ready. in_ready=1 only in IDLE and FILL with widx<16.
- IDLE: first transfer writes word 0; state goes to FILL (or to PAD if in_last).
- FILL: each transfer writes word widx and widx++; bit length += 32, or += 8*in_bytes on the last word.
  - widx reaching 16 without last -> ISSUE with blk_last=0.
  - in_last, in_bytes<4: bytes beyond in_bytes are zeroed; byte in_bytes is set to 0x80; go to PAD.
  - in_last, in_bytes=4: the 0x80 is deferred; it goes in the next word's [31:24], written in PAD.
- PAD (one word per cycle, no input accepted):
  - Write the pending 0x80 word if deferred.
  - Zero-fill to widx=14.
  - If widx<=14 when PAD is entered: words 14/15 get length[63:32] / length[31:0]; blk_last=1; go to ISSUE.
  - If widx>14 (0x80 landed in word 14 or 15, or deferred past 15): zero-fill to 16; ISSUE with blk_last=0; set the extra-block flag. After hash_done, the next block is all zeros except the length.
- ISSUE: blk_start=1 for exactly one cycle; go to WAIT.
- WAIT: blk_data stable; no input accepted. On hash_done:
  - clear the buffer and set widx=0;
  - return to FILL (message continuing), PAD (extra-block or deferred-0x80 pending), or IDLE (blk_last=1).
  - On the blk_last case, msg_done pulses in the cycle after hash_done.
- hash_done outside WAIT is ignored. in_valid in PAD/ISSUE/WAIT is back-pressured.
- Latency: last word accepted -> blk_start within (16-widx)+2 cycles.
- Length counter saturates at 2^LEN_W-1. Dropped overflow words do not count toward the length.
- Reset mid-operation: immediate return to reset values. No blk_start or msg_done is emitted afterwards for the aborted message.

Optional Feature:
SHA256_PAD_BYTESWAP_EN:
- Defined: in_data is byte-reversed on input (little-endian host, first byte in [7:0]). in_bytes then counts from the low byte.
- Undefined: in_data is used as-is (big-endian).
- Padding, length and blk_data layout are identical in both cases.

Decomposition:
Shared package sha256_pkg holds:
- state enum (IDLE, FILL, PAD, ISSUE, WAIT);
- constants SHA256_BLOCK_W=512, SHA256_WORD_W=32, SHA256_WORDS=16, SHA256_LEN_HI_IDX=14, SHA256_LEN_LO_IDX=15, SHA256_PAD_BYTE=8'h80.

One combinational sub-module, sha256_pad_word: masks the bytes of the last word and inserts the 0x80 byte from in_bytes.

Test Plan:
- "abc" (in_data=0x61626300, in_last, in_bytes=3) -> one block: word0=0x61626380, words 1..14=0, word15=0x00000018, blk_last=1; msg_done follows hash_done.
- 55-byte message (13 full words + 3 bytes) -> single block: word13 ends in 0x80, word14=0, word15=0x000001B8.
- 56-byte message (14 full words, in_bytes=4) -> block 1: word14=0x80000000, word15=0, blk_last=0. Block 2: words 0..13=0, word15=0x000001C0, blk_last=1.
- 64-byte message, then hold in_valid=1 -> in_ready=0 during WAIT. Block 2 word0=0x80000000, word15=0x00000200. Exactly two blk_start pulses.
- Assert reset during WAIT of block 1 -> all outputs zero immediately. A later hash_done produces no msg_done; the next "abc" yields a correct single block.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder and its word helper.
// The state type mirrors the padder FSM; the byte-swap helper serves SHA256_PAD_BYTESWAP_EN builds.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        PAD   = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4
    } sha256_state_e;

    localparam int         SHA256_BLOCK_W     = 512;
    localparam int         SHA256_WORD_W      = 32;
    localparam int         SHA256_WORDS       = 16;
    localparam int         SHA256_LEN_HI_IDX  = 14;
    localparam int         SHA256_LEN_LO_IDX  = 15;
    localparam logic [7:0] SHA256_PAD_BYTE    = 8'h80;

    function automatic logic [SHA256_WORD_W-1:0] sha256_bswap32(input logic [SHA256_WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Conditions one incoming message word: on the final word it zeroes the unused
// bytes, drops the 0x80 marker right after the last valid byte and reports the bit count.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [SHA256_WORD_W-1:0] data,
    input  logic                     last,
    input  logic [2:0]               nbytes,
    output logic [SHA256_WORD_W-1:0] word,
    output logic                     pad_inserted,
    output logic [5:0]               bits
);

    logic [2:0] nb;

    always_comb begin
        // 0 and 5..7 mean a full word
        nb = ((nbytes == 3'd0) || (nbytes > 3'd4)) ? 3'd4 : nbytes;
        word = '0;
        for (int k = 0; k < 4; k++) begin
            if (!last || (3'(k) < nb)) begin
                word[31-8*k -: 8] = data[31-8*k -: 8];
            end else if (3'(k) == nb) begin
                word[31-8*k -: 8] = SHA256_PAD_BYTE;
            end
        end
        pad_inserted = last && (nb != 3'd4);
        bits         = last ? {nb, 3'b000} : 6'd32;
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Streams 32-bit message words into FIPS 180-4 padded 512-bit blocks for sha256_module.
// Define SHA256_PAD_BYTESWAP_EN to accept little-endian host words (first byte in [7:0]).
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W     = 64,
    parameter int MAX_WORDS = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SHA256_WORD_W-1:0]  in_data,
    input  logic                      in_last,
    input  logic [2:0]                in_bytes,
    output logic [SHA256_BLOCK_W-1:0] blk_data,
    output logic                      blk_start,
    output logic                      blk_last,
    input  logic                      hash_done,
    output logic                      msg_done,
    output logic                      overflow
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_FILL  = FILL;
    localparam logic [2:0] ST_PAD   = PAD;
    localparam logic [2:0] ST_ISSUE = ISSUE;
    localparam logic [2:0] ST_WAIT  = WAIT;

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int SUM_W = ((LEN_W > 6) ? LEN_W : 6) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [2:0]               state;
    logic [4:0]               widx;
    logic [SHA256_WORD_W-1:0] words_q [SHA256_WORDS];
    logic [LEN_W-1:0]         bit_len;
    logic [CNT_W-1:0]         wcount;
    logic                     pend_80;
    logic                     more_blk;
    logic                     len_lo;

    logic [SHA256_WORD_W-1:0] host_word;
    logic [SHA256_WORD_W-1:0] pad_word;
    logic                     pad_ins;
    logic [5:0]               word_bits;
    logic                     xfer;
    logic                     drop;
    logic [LEN_W-1:0]         len_base;
    logic [SUM_W-1:0]         len_sum;
    logic [LEN_W-1:0]         len_next;
    logic [63:0]              len64;

`ifdef SHA256_PAD_BYTESWAP_EN
    assign host_word = sha256_bswap32(in_data);
`else
    assign host_word = in_data;
`endif

    sha256_pad_word u_pad_word (
        .data         (host_word),
        .last         (in_last),
        .nbytes       (in_bytes),
        .word         (pad_word),
        .pad_inserted (pad_ins),
        .bits         (word_bits)
    );

    // Handshake: a word moves on in_valid && in_ready; in_ready never depends on in_valid.
    assign in_ready  = !reset && ((state == ST_IDLE) || ((state == ST_FILL) && (widx < 5'd16)));
    assign xfer      = in_valid && in_ready;
    assign drop      = (state == ST_FILL) && (wcount >= CNT_W'(MAX_WORDS));
    assign blk_start = (state == ST_ISSUE);
    assign len64     = 64'(bit_len);

    // A new message restarts the length from zero; the counter saturates at LEN_MAX.
    always_comb begin
        len_base = (state == ST_IDLE) ? '0 : bit_len;
        len_sum  = SUM_W'(len_base) + SUM_W'(word_bits);
        if (len_sum > SUM_W'(LEN_MAX)) begin
            len_next = LEN_MAX;
        end else begin
            len_next = len_sum[LEN_W-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < SHA256_WORDS; i++) begin
            blk_data[SHA256_WORD_W*i +: SHA256_WORD_W] = words_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            widx     <= 5'd0;
            for (int i = 0; i < SHA256_WORDS; i++) begin
                words_q[i] <= '0;
            end
            bit_len  <= '0;
            wcount   <= '0;
            pend_80  <= 1'b0;
            more_blk <= 1'b0;
            len_lo   <= 1'b0;
            blk_last <= 1'b0;
            msg_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        words_q[0] <= pad_word;
                        widx       <= 5'd1;
                        bit_len    <= len_next;
                        wcount     <= CNT_W'(1);
                        overflow   <= 1'b0;
                        pend_80    <= in_last && !pad_ins;
                        state      <= in_last ? ST_PAD : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (xfer) begin
                        if (drop) begin
                            // Dropped words add nothing, but a dropped last word still closes the message.
                            overflow <= 1'b1;
                            if (in_last) begin
                                pend_80 <= 1'b1;
                                state   <= ST_PAD;
                            end
                        end else begin
                            words_q[widx[3:0]] <= pad_word;
                            widx               <= widx + 5'd1;
                            bit_len            <= len_next;
                            wcount             <= wcount + CNT_W'(1);
                            if (in_last) begin
                                pend_80 <= !pad_ins;
                                state   <= ST_PAD;
                            end else if (widx == 5'd15) begin
                                blk_last <= 1'b0;
                                more_blk <= 1'b0;
                                state    <= ST_ISSUE;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (widx == 5'd16) begin
                        // No room for the length: ship this block and pad another (pend_80 may carry over).
                        blk_last <= 1'b0;
                        more_blk <= 1'b1;
                        state    <= ST_ISSUE;
                    end else if (pend_80) begin
                        words_q[widx[3:0]] <= {SHA256_PAD_BYTE, 24'h0};
                        pend_80            <= 1'b0;
                        widx               <= widx + 5'd1;
                    end else if (len_lo) begin
                        words_q[SHA256_LEN_LO_IDX] <= len64[31:0];
                        len_lo   <= 1'b0;
                        blk_last <= 1'b1;
                        more_blk <= 1'b0;
                        state    <= ST_ISSUE;
                    end else if (widx == 5'd14) begin
                        words_q[SHA256_LEN_HI_IDX] <= len64[63:32];
                        len_lo <= 1'b1;
                        widx   <= 5'd15;
                    end else begin
                        words_q[widx[3:0]] <= '0;
                        widx               <= widx + 5'd1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (hash_done) begin
                        for (int i = 0; i < SHA256_WORDS; i++) begin
                            words_q[i] <= '0;
                        end
                        widx   <= 5'd0;
                        len_lo <= 1'b0;
                        if (blk_last) begin
                            blk_last <= 1'b0;
                            msg_done <= 1'b1;
                            state    <= ST_IDLE;
                        end else if (more_blk) begin
                            more_blk <= 1'b0;
                            state    <= ST_PAD;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: table of messages against a byte-level
// FIPS 180-4 padding model, plus hand sequences for "abc" and reset during WAIT.
module tb_sha256_msg_padder;

    localparam int TB_MAX_WORDS = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] blk_data;
    logic         blk_start;
    logic         blk_last;
    logic         hash_done;
    logic         msg_done;
    logic         overflow;

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(64), .MAX_WORDS(TB_MAX_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_data  (blk_data),
        .blk_start (blk_start),
        .blk_last  (blk_last),
        .hash_done (hash_done),
        .msg_done  (msg_done),
        .overflow  (overflow)
    );

    typedef struct {
        string       name;
        int          send_bytes;
        int          model_bytes;
        bit          hold;
        int          exp_blocks;
        logic [31:0] exp_w15;
        bit          exp_ovf;
        int          chk_blk;
        int          chk_word;
        logic [31:0] chk_val;
    } vec_t;

    vec_t         vecs[11];
    logic [511:0] exp_q[$];
    bit           exp_last_q[$];
    logic [511:0] got_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_done   = 0;
    int bad_ready = 0;
    bit hold_mon = 1'b0;
    bit resp_on  = 1'b1;
    int hold_target = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] to_host(input logic [31:0] w);
`ifdef SHA256_PAD_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Reference padding: message byte k is k+1, then 0x80, zeros, 64-bit big-endian bit length.
    task automatic push_expected(input int nbytes);
        int           total;
        int           nblk;
        logic [63:0]  nbits;
        logic [7:0]   b;
        logic [511:0] blk;
        total = ((nbytes + 8) / 64 + 1) * 64;
        nblk  = total / 64;
        nbits = 64'(nbytes) * 64'd8;
        for (int bl = 0; bl < nblk; bl++) begin
            blk = '0;
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 4; j++) begin
                    int k;
                    k = 64 * bl + 4 * i + j;
                    if (k < nbytes) b = 8'(k + 1);
                    else if (k == nbytes) b = 8'h80;
                    else if (k >= total - 8) b = nbits[8*(total-1-k) +: 8];
                    else b = 8'h00;
                    blk[32*i + 8*(3-j) +: 8] = b;
                end
            end
            exp_q.push_back(blk);
            exp_last_q.push_back(bl == nblk - 1);
        end
    endtask

    task automatic drive_word(input logic [31:0] w, input bit last, input logic [2:0] nb);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = to_host(w);
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready=0 after %0d cycles, required 1", waited);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_msg(input int nbytes, input bit hold);
        int          nw;
        int          lastb;
        int          waited;
        logic [31:0] w;
        nw    = (nbytes + 3) / 4;
        lastb = nbytes - 4 * (nw - 1);
        for (int j = 0; j < nw; j++) begin
            for (int q = 0; q < 4; q++) begin
                w[31-8*q -: 8] = (4*j + q < nbytes) ? 8'(4*j + q + 1) : 8'hEE;
            end
            drive_word(w, j == nw - 1, (j == nw - 1) ? 3'(lastb) : 3'($urandom_range(0, 7)));
        end
        if (hold) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = 32'hDEADBEEF;
            hold_mon = 1'b1;
            waited   = 0;
            while (n_start < hold_target && waited < 400) begin
                @(posedge clk); #1;
                waited++;
            end
            hold_mon = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_msg_done(input int d0);
        int waited = 0;
        while (n_done == d0 && waited < 600) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("msg_done_pulses", 512'(n_done - d0), 512'(1));
    endtask

    always @(negedge clk) begin
        if (blk_start) n_start++;
        if (msg_done) n_done++;
        if (hold_mon && in_ready) bad_ready++;
    end

    // Hasher model: capture each block, hold it a few cycles, then pulse hash_done.
    initial begin
        logic [511:0] cap;
        logic [511:0] e;
        bit           el;
        forever begin
            @(posedge clk); #2;
            if (blk_start && resp_on) begin
                cap = blk_data;
                got_q.push_back(cap);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_block: got %0h, required no block", cap);
                end else begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("blk_data", cap, e);
                    check("blk_last", 512'(blk_last), 512'(el));
                end
                repeat (3) begin
                    @(posedge clk); #2;
                end
                check("blk_hold", blk_data, cap);
                check("wait_in_ready", 512'(in_ready), 512'(0));
                hash_done = 1'b1;
                @(posedge clk); #2;
                hash_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] exp;
        int d0;
        int s0;
        int s1;
        int d1;
        int waited;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0; hash_done = 1'b0;

        vecs[0]  = '{"b1",       1,   1,   0, 1, 32'h00000008, 0, 0, 0,  32'h01800000};
        vecs[1]  = '{"b3",       3,   3,   0, 1, 32'h00000018, 0, 0, 0,  32'h01020380};
        vecs[2]  = '{"b4",       4,   4,   0, 1, 32'h00000020, 0, 0, 1,  32'h80000000};
        vecs[3]  = '{"b55",      55,  55,  0, 1, 32'h000001B8, 0, 0, 13, 32'h35363780};
        vecs[4]  = '{"b56",      56,  56,  0, 2, 32'h000001C0, 0, 0, 14, 32'h80000000};
        vecs[5]  = '{"b60",      60,  60,  0, 2, 32'h000001E0, 0, 0, 15, 32'h80000000};
        vecs[6]  = '{"b63",      63,  63,  0, 2, 32'h000001F8, 0, 0, 15, 32'h3D3E3F80};
        vecs[7]  = '{"b64_hold", 64,  64,  1, 2, 32'h00000200, 0, 1, 0,  32'h80000000};
        vecs[8]  = '{"b120",     120, 120, 0, 3, 32'h000003C0, 0, 1, 14, 32'h80000000};
        vecs[9]  = '{"ovf144",   144, 128, 0, 3, 32'h00000400, 1, 2, 0,  32'h80000000};
        vecs[10] = '{"b70",      70,  70,  0, 2, 32'h00000230, 0, 1, 1,  32'h45468000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_data",  blk_data, '0);
        check("rst_blk_start", 512'(blk_start), 512'(0));
        check("rst_blk_last",  512'(blk_last), 512'(0));
        check("rst_msg_done",  512'(msg_done), 512'(0));
        check("rst_overflow",  512'(overflow), 512'(0));
        check("rst_in_ready",  512'(in_ready), 512'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", 512'(in_ready), 512'(1));

        // "abc" as a single big-endian word
        exp = '0;
        exp[31:0]    = 32'h61626380;
        exp[511:480] = 32'h00000018;
        exp_q.push_back(exp);
        exp_last_q.push_back(1'b1);
        got_q.delete();
        d0 = n_done; s0 = n_start;
        drive_word(32'h61626300, 1'b1, 3'd3);
        in_valid = 1'b0; in_last = 1'b0;
        wait_msg_done(d0);
        check("abc_blocks", 512'(n_start - s0), 512'(1));
        check("abc_exp_empty", 512'(exp_q.size()), 512'(0));

        for (int v = 0; v < 11; v++) begin
            got_q.delete();
            push_expected(vecs[v].model_bytes);
            d0 = n_done; s0 = n_start;
            hold_target = s0 + vecs[v].exp_blocks;
            bad_ready = 0;
            send_msg(vecs[v].send_bytes, vecs[v].hold);
            wait_msg_done(d0);
            check({vecs[v].name, "_blocks"}, 512'(n_start - s0), 512'(vecs[v].exp_blocks));
            check({vecs[v].name, "_exp_empty"}, 512'(exp_q.size()), 512'(0));
            check({vecs[v].name, "_overflow"}, 512'(overflow), 512'(vecs[v].exp_ovf));
            if (got_q.size() > vecs[v].chk_blk) begin
                check({vecs[v].name, "_w15"}, 512'(got_q[got_q.size()-1][511:480]), 512'(vecs[v].exp_w15));
                check({vecs[v].name, "_pad_word"},
                      512'(got_q[vecs[v].chk_blk][32*vecs[v].chk_word +: 32]), 512'(vecs[v].chk_val));
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_captured: got %0d blocks, required more than %0d", vecs[v].name,
                         got_q.size(), vecs[v].chk_blk);
            end
            if (vecs[v].hold) check({vecs[v].name, "_hold_ready"}, 512'(bad_ready), 512'(0));
            while (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end
        end

        // Reset while block 1 of "abc" waits for the hasher
        resp_on = 1'b0;
        d0 = n_done; s0 = n_start;
        drive_word(32'h61626300, 1'b1, 3'd3);
        in_valid = 1'b0; in_last = 1'b0;
        waited = 0;
        while (n_start == s0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("abort_blk_start_seen", 512'(n_start - s0), 512'(1));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_blk_data",  blk_data, '0);
        check("abort_blk_start", 512'(blk_start), 512'(0));
        check("abort_blk_last",  512'(blk_last), 512'(0));
        check("abort_msg_done",  512'(msg_done), 512'(0));
        check("abort_in_ready",  512'(in_ready), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        d1 = n_done; s1 = n_start;
        hash_done = 1'b1;
        @(posedge clk); #1;
        hash_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_msg_done", 512'(n_done - d1), 512'(0));
        check("abort_no_blk_start", 512'(n_start - s1), 512'(0));
        check("abort_total_done", 512'(n_done - d0), 512'(0));
        resp_on = 1'b1;

        // Fresh "abc" after the abort; garbage in the unused byte must be masked
        exp = '0;
        exp[31:0]    = 32'h61626380;
        exp[511:480] = 32'h00000018;
        exp_q.push_back(exp);
        exp_last_q.push_back(1'b1);
        got_q.delete();
        d0 = n_done; s0 = n_start;
        drive_word(32'h616263AA, 1'b1, 3'd3);
        in_valid = 1'b0; in_last = 1'b0;
        wait_msg_done(d0);
        check("abc2_blocks", 512'(n_start - s0), 512'(1));
        check("abc2_exp_empty", 512'(exp_q.size()), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
